// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM type, counter width and access-fault helper
package dmem_responder_pkg;
  localparam int FAULT_CNT_W = 16;
  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} fsm_state_t;
  // Faulted when not word aligned or beyond the last byte of the array.
  function automatic logic is_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr >= 32'(depth) * 32'd4);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word memory with synchronous write and registered read
// Ports: clk, rst (sync, clears read register only), we/wdata write port,
//        re loads rdata from mem[idx], idx word index, rdata registered read data.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;
  always_comb rdata_d = rst ? 32'h0 : (re ? mem[idx] : rdata_q);
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with tristate read return and fault flagging
// Ports: clk, rst (sync active-high), dmem_addr byte address, dmem_wen 1=write/0=read,
//        dmem_data bidirectional data bus, fault one-cycle fault pulse,
//        fault_cnt saturating fault count (only when DMEM_FAULT_CNT_EN is defined, else 0).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 1024,
  parameter int          ADDR_W         = $clog2(DEPTH_WORDS),
  parameter logic [31:0] FAULT_READ_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_wen,
  inout  wire  [31:0] dmem_data,
  output logic        fault,
  output logic [15:0] fault_cnt
);
  fsm_state_t  state_q, state_d;
  logic        rd_fault_q, rd_fault_d;
  logic        fault_q, fault_d;
  logic        acc_fault;
  logic [31:0] arr_rdata;
  logic [31:0] rd_val;
  assign acc_fault = is_fault(dmem_addr, DEPTH_WORDS);
  // Both states share the same transitions: a read edge drives next, a write edge releases.
  always_comb begin
    state_d    = rst ? IDLE : (dmem_wen ? IDLE : DRIVE);
    rd_fault_d = rst ? 1'b0 : (dmem_wen ? rd_fault_q : acc_fault);
    fault_d    = rst ? 1'b0 : acc_fault;
  end
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    rd_fault_q <= rd_fault_d;
    fault_q    <= fault_d;
  end
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (dmem_wen & ~acc_fault & ~rst),
    .re   (~dmem_wen),
    .idx  (dmem_addr[ADDR_W+1:2]),
    .wdata(dmem_data),
    .rdata(arr_rdata)
  );
  assign rd_val = rd_fault_q ? FAULT_READ_VAL : arr_rdata;
  // Gating on dmem_wen and rst releases the bus in the very cycle a write or reset appears.
  assign dmem_data = (state_q == DRIVE && !dmem_wen && !rst) ? rd_val : 'z;
  // Outputs are forced low while rst is high, even on the first reset cycle.
  assign fault = fault_q & ~rst;
`ifdef DMEM_FAULT_CNT_EN
  logic [FAULT_CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = rst ? '0 : ((acc_fault && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q);
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end
  assign fault_cnt = cnt_q & {FAULT_CNT_W{~rst}};
`else
  assign fault_cnt = '0;
`endif
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle-issue RV32I pipeline core. It sits on the far end of the core's data-memory port (`dmem_addr`, `dmem_wen`, bidirectional `dmem_data`) and completes word writes and word reads. Reads have a fixed one-cycle registered latency. The block owns bus direction, and it flags misaligned or out-of-range accesses.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH_WORDS): word-index width (derived, not overridden).
- FAULT_READ_VAL, 32'h0000_0000: value returned for a faulted read.

Ports:
- clk, input, 1: sole clock; everything samples on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- dmem_addr, input, 32: byte address from the core.
- dmem_wen, input, 1: 1 means write this cycle; 0 means read this cycle.
- dmem_data, inout, 32: driven by the core when dmem_wen=1; driven by this block only per the drive rule; high-Z otherwise.
- fault, output, 1: registered one-cycle pulse for a misaligned or out-of-range access.
- fault_cnt, output, 16: saturating count of faults (see Configuration).

## Operation
- Word index is dmem_addr[ADDR_W+1:2].
- An access is faulted when dmem_addr[1:0] != 0 or dmem_addr >= DEPTH_WORDS*4.
- Write (edge with dmem_wen=1, no fault): mem[index] <= dmem_data. A faulted write leaves memory unchanged.
- Read (edge with dmem_wen=0): rd_q <= mem[index], or FAULT_READ_VAL if faulted.
- FSM state register, two states:
  - IDLE: bus released. An edge with dmem_wen=0 goes to DRIVE; an edge with dmem_wen=1 stays in IDLE.
  - DRIVE: rd_q presented. An edge with dmem_wen=0 stays in DRIVE and reloads rd_q; an edge with dmem_wen=1 goes to IDLE.
- Drive rule: dmem_data = rd_q when (state==DRIVE && !dmem_wen && !rst), else 'z.
  - The combinational gating on dmem_wen and rst means the block never contends with a core write in the same cycle.
- Read-after-write to the same address in the next cycle returns the newly written data, because the write commits at the edge before the read samples.
- fault <= 1 for exactly one cycle after each faulted edge; back-to-back faults hold it high.
- Reset:
  - state <= IDLE, rd_q <= 0, fault <= 0, fault_cnt <= 0.
  - Memory contents are not cleared; the simulation initial value is all zeros.
  - Reset asserted mid-read releases the bus in the same cycle.

## Timing
- Write latency: committed at the sampling edge and visible to a read sampled at the next edge.
- Read latency: address sampled at edge N; data valid on dmem_data from just after edge N through edge N+1 (one full cycle).
- Back-to-back reads give one new word per cycle with no bubble.
- Write to read switch: no turnaround cycle is needed. Write cycle N is followed by read sample N+1, and the block drives in cycle N+2.
- Read to write switch: the bus is released combinationally in the write cycle itself.
- fault and fault_cnt update one edge after the faulted access.
- Every output is 0 or Z while rst is high.

## Configuration
- DMEM_FAULT_CNT_EN:
  - Defined: fault_cnt increments by 1 on each faulted edge and saturates at 16'hFFFF.
  - Undefined: the counter logic is removed and fault_cnt is tied to 0.
  - The fault pulse and read/write suppression are unaffected either way.

## Structure
- A shared package holds:
  - the fsm_state_t enum {IDLE, DRIVE};
  - the FAULT_CNT_W=16 constant;
  - the helper function is_fault(addr, depth).
- One sub-module, dmem_array: synchronous write, registered read, parameterized by DEPTH_WORDS.
- The top level holds the FSM, the tristate driver, and the fault logic.

## Test plan
- Write 0xCAFE_F00D to 0x10, then read 0x10 -> dmem_data = 0xCAFE_F00D during the cycle after the read sample; bus Z during the write cycle.
- Reads of 0x0, 0x4, 0x8 back-to-back (preloaded 1, 2, 3) -> 1, 2, 3 on consecutive cycles; state stays DRIVE.
- Read of 0x4 followed immediately by a write to 0x8 -> block releases dmem_data in the write cycle (no X on the bus); mem[2] holds the written value.
- Misaligned write to 0x6 with data 0xFFFF_FFFF, then read 0x4 -> previous value unchanged; fault pulses once; fault_cnt = 1 (macro on) or 0 (macro off).
- Read of 0x1000 with DEPTH_WORDS=1024 -> returns FAULT_READ_VAL; fault high one cycle.
- rst asserted while in DRIVE -> bus Z in the same cycle; after release state is IDLE and fault_cnt = 0; memory retains prior data.
